// File: rtl/mem_pattern_tester_pkg.sv
// Shared encodings for the memory pattern tester: pattern modes, FSM states, LFSR taps.
package mem_tester_pkg;

    localparam logic [1:0] PAT_LFSR  = 2'd0;
    localparam logic [1:0] PAT_ADDR  = 2'd1;
    localparam logic [1:0] PAT_NADDR = 2'd2;
    localparam logic [1:0] PAT_WALK  = 2'd3;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_START,
        ST_WR,
        ST_RSTART,
        ST_RD,
        ST_DONE
    } state_t;

    // Right-shifting Galois step; the feedback bit is the one shifted out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/mem_pattern_tester_if.sv
// Single-outstanding request/ack memory bus between the tester (master) and a controller (slave).
interface mem_pattern_tester_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 24
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_pattern_tester_pattern_gen.sv
// Pattern word generator: holds the LFSR and the shadow copy used to replay a pass's write data.
module pattern_gen
    import mem_tester_pkg::*;
#(
    parameter int          DATA_W = 16,
    parameter int          ADDR_W = 24,
    parameter logic [31:0] SEED   = 32'hACE1_1234
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic              step,
    input  logic              save,
    input  logic              restore,
    output logic [DATA_W-1:0] pattern
);

    logic [31:0]       r_lfsr;
    logic [31:0]       r_shadow;
    logic [DATA_W-1:0] w_addr_word;
    logic [ADDR_W-1:0] w_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr   <= SEED;
            r_shadow <= SEED;
        end else begin
            if (save)
                r_shadow <= r_lfsr;
            if (restore)
                r_lfsr <= r_shadow;
            else if (step)
                r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    always_comb begin
        w_addr_word = DATA_W'(addr);
        w_bit       = addr % ADDR_W'(DATA_W);
        case (mode)
            PAT_ADDR:  pattern = w_addr_word;
            PAT_NADDR: pattern = ~w_addr_word;
            PAT_WALK:  pattern = DATA_W'(1) << w_bit;
            default:   pattern = r_lfsr[DATA_W-1:0];
        endcase
    end

endmodule

// File: rtl/mem_pattern_tester.sv
// Write-then-verify soak tester over addresses 0..addr_last of a request/ack memory.
// Optional first-failure capture outputs are built when MEM_TESTER_ERR_CAPTURE_EN is defined.
module mem_pattern_tester
    import mem_tester_pkg::*;
#(
    parameter int          DATA_W      = 16,
    parameter int          ADDR_W      = 24,
    parameter logic [31:0] SEED        = 32'hACE1_1234,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr_last,
    input  logic              mem_init_done,
    mem_pattern_tester_if.master bus,
    output logic              busy,
    output logic [31:0]       passcount,
    output logic [31:0]       failcount,
    output logic              timeout
`ifdef MEM_TESTER_ERR_CAPTURE_EN
    ,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got
`endif
);

    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_addr_last;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_mode;
    logic              r_busy;
    logic              r_timeout;
    logic [31:0]       r_pass;
    logic [31:0]       r_fail;
    logic [TMR_W-1:0]  r_tmr;

    logic              w_accept;
    logic              w_last;
    logic              w_mismatch;
    logic [DATA_W-1:0] w_pattern;

    assign w_accept   = r_req & bus.mem_ack;
    assign w_last     = (r_addr == r_addr_last);
    // r_wdata holds the expected word during reads as well as the write data.
    assign w_mismatch = w_accept & (r_state == ST_RD) & (bus.mem_rdata != r_wdata);

    pattern_gen #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .SEED   (SEED)
    ) u_pattern_gen (
        .clk     (clk),
        .rst     (rst),
        .mode    (r_mode),
        .addr    (r_addr),
        .step    (w_accept),
        .save    (r_state == ST_START),
        .restore (r_state == ST_RSTART),
        .pattern (w_pattern)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_addr_last <= '0;
            r_wdata     <= '0;
            r_mode      <= PAT_LFSR;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_tmr       <= '0;
        end else begin
            case (r_state)
                ST_IDLE:
                    if (enable && !r_timeout)
                        r_state <= ST_WAIT_INIT;
                ST_WAIT_INIT:
                    if (mem_init_done)
                        r_state <= ST_START;
                ST_START: begin
                    r_mode      <= mode;
                    r_addr_last <= addr_last;
                    r_addr      <= '0;
                    r_busy      <= 1'b1;
                    r_state     <= ST_WR;
                end
                ST_WR, ST_RD: begin
                    // A request launches only from req=0, giving the mandatory idle cycle after each ack.
                    if (!r_req) begin
                        r_req   <= 1'b1;
                        r_we    <= (r_state == ST_WR);
                        r_wdata <= w_pattern;
                        r_tmr   <= '0;
                    end else if (bus.mem_ack) begin
                        r_req <= 1'b0;
                        if (w_mismatch && (r_fail != 32'hFFFF_FFFF))
                            r_fail <= r_fail + 32'd1;
                        if (w_last)
                            r_state <= (r_state == ST_WR) ? ST_RSTART : ST_DONE;
                        else
                            r_addr <= r_addr + 1'b1;
                    end else if (r_tmr == TMR_LAST) begin
                        r_req     <= 1'b0;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                ST_RSTART: begin
                    r_addr  <= '0;
                    r_state <= ST_RD;
                end
                ST_DONE: begin
                    r_pass <= r_pass + 32'd1;
                    if (enable) begin
                        r_state <= ST_START;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = r_req;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign busy          = r_busy;
    assign passcount     = r_pass;
    assign failcount     = r_fail;
    assign timeout       = r_timeout;

`ifdef MEM_TESTER_ERR_CAPTURE_EN
    logic              r_fail_valid;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_exp;
    logic [DATA_W-1:0] r_fail_got;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail_valid <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_exp   <= '0;
            r_fail_got   <= '0;
        end else if (w_mismatch && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_addr  <= r_addr;
            r_fail_exp   <= r_wdata;
            r_fail_got   <= bus.mem_rdata;
        end
    end

    assign fail_valid = r_fail_valid;
    assign fail_addr  = r_fail_addr;
    assign fail_exp   = r_fail_exp;
    assign fail_got   = r_fail_got;
`endif

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Directed-plus-random bench for mem_pattern_tester with a latency-randomised memory model
// and a pattern reference computed from the pattern definitions.
module tb_mem_pattern_tester;

    localparam int          DW   = 16;
    localparam int          AW   = 24;
    localparam int          TO   = 16;
    localparam logic [31:0] SEED = 32'hACE1_1234;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          mem_init_done = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] addr_last = '0;
    logic          busy;
    logic          timeout;
    logic [31:0]   passcount;
    logic [31:0]   failcount;
`ifdef MEM_TESTER_ERR_CAPTURE_EN
    logic          fail_valid;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp;
    logic [DW-1:0] fail_got;
`endif

    mem_pattern_tester_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_pattern_tester #(
        .DATA_W(DW), .ADDR_W(AW), .SEED(SEED), .TIMEOUT_CYC(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .mode          (mode),
        .addr_last     (addr_last),
        .mem_init_done (mem_init_done),
        .bus           (bus),
        .busy          (busy),
        .passcount     (passcount),
        .failcount     (failcount),
        .timeout       (timeout)
`ifdef MEM_TESTER_ERR_CAPTURE_EN
        ,
        .fail_valid    (fail_valid),
        .fail_addr     (fail_addr),
        .fail_exp      (fail_exp),
        .fail_got      (fail_got)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: kind 0 ideal, 1 bit 3 stuck at one on reads, 2 never acks.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } xact_t;

    int            mem_kind = 0;
    int            lat_max = 0;
    logic          stray = 1'b0;
    logic [DW-1:0] mem [64];
    xact_t         log_q [$];
    int            dly = 0;
    int            hs_err = 0;
    int            run_len = 0;
    int            last_run = 0;
    logic          prev_req = 1'b0;
    logic          prev_ack = 1'b0;
    logic          prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wd = '0;

    always @(negedge clk) begin
        if (prev_req && !prev_ack && bus.mem_req &&
            (bus.mem_addr !== prev_addr || bus.mem_we !== prev_we || bus.mem_wdata !== prev_wd))
            hs_err++;
        if (prev_req && prev_ack && bus.mem_req)
            hs_err++;
        if (bus.mem_req) run_len++;
        else if (run_len > 0) begin
            last_run = run_len;
            run_len = 0;
        end
        prev_req  = bus.mem_req;
        prev_we   = bus.mem_we;
        prev_addr = bus.mem_addr;
        prev_wd   = bus.mem_wdata;
        if (rst) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
            dly = 0;
            hs_err = 0;
            run_len = 0;
            last_run = 0;
            log_q.delete();
        end else if (stray) begin
            bus.mem_ack = 1'b1;
        end else if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
        end else if (bus.mem_req && mem_kind != 2) begin
            if (dly > 0) dly--;
            else begin
                bus.mem_ack = 1'b1;
                if (bus.mem_we) mem[bus.mem_addr[5:0]] = bus.mem_wdata;
                else bus.mem_rdata = mem[bus.mem_addr[5:0]] | ((mem_kind == 1) ? 16'h0008 : 16'h0000);
                log_q.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
                dly = int'($urandom_range(lat_max, 0));
            end
        end
        prev_ack = bus.mem_ack;
    end

    // Reference: LFSR value after n accepted words, and the word a pattern mode gives.
    function automatic logic [31:0] lfsr_at(input int n);
        logic [31:0] x;
        x = SEED;
        for (int i = 0; i < n; i++)
            x = x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
        return x;
    endfunction

    function automatic logic [DW-1:0] ref_pat(input int m, input int a, input int n);
        logic [31:0]   l;
        logic [DW-1:0] aw;
        aw = DW'(a);
        case (m)
            0: begin
                l = lfsr_at(n);
                return l[DW-1:0];
            end
            1: return aw;
            2: return ~aw;
            default: return DW'(1) << (a % DW);
        endcase
    endfunction

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        tick(2);
        rst = 1'b0;
        tick();
    endtask

    // Pass p, word a of the log: writes 0..nw-1 then reads 0..nw-1; LFSR index p*nw+a.
    task automatic check_log(input string tag, input int m, input int nw, input int np);
        chk({tag, "_len"}, log_q.size(), 2 * nw * np);
        for (int k = 0; k < log_q.size() && k < 2 * nw * np; k++) begin
            int p, w, a;
            p = k / (2 * nw);
            w = k % (2 * nw);
            a = w % nw;
            chk({tag, "_we"}, log_q[k].we, (w < nw) ? 1 : 0);
            chk({tag, "_addr"}, log_q[k].a, a);
            if (w < nw)
                chk({tag, "_wdata"}, log_q[k].d, ref_pat(m, a, p * nw + a));
        end
    endtask

    // Runs np passes; enable drops during the WR phase of the last pass, together with
    // mode/addr_last changes that must not affect the pass in flight.
    task automatic run(input bit do_rst, input int m, input int al, input int kind,
                       input int lat, input int np);
        if (do_rst) do_reset();
        mode = 2'(m);
        addr_last = AW'(al);
        mem_kind = kind;
        lat_max = lat;
        mem_init_done = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 20000 && passcount != 32'(np - 1); i++) tick();
        for (int i = 0; i < 500 && !(bus.mem_req && bus.mem_we); i++) tick();
        enable = 1'b0;
        mode = 2'(m + 1);
        addr_last = AW'(al + 2);
        for (int i = 0; i < 5000 && busy; i++) tick();
        chk("run_idle", busy, 0);
    endtask

    initial begin
        do_reset();
        chk("rst_req", bus.mem_req, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pass", passcount, 0);
        chk("rst_fail", failcount, 0);
        chk("rst_timeout", timeout, 0);

        // Controller not initialised: no traffic.
        enable = 1'b1;
        tick(6);
        chk("noinit_req", bus.mem_req, 0);
        chk("noinit_busy", busy, 0);

        // LFSR, 3 passes over 16 words, random latency.
        run(1'b0, 0, 15, 0, 3, 3);
        chk("lfsr_pass", passcount, 3);
        chk("lfsr_fail", failcount, 0);
        chk("lfsr_timeout", timeout, 0);
        chk("lfsr_hs", hs_err, 0);
        check_log("lfsr", 0, 16, 3);

        // Address pattern against bit 3 stuck at one: 8 bad words per pass.
        run(1'b1, 1, 15, 1, 2, 2);
        chk("stuck_pass", passcount, 2);
        chk("stuck_fail", failcount, 16);
        chk("stuck_hs", hs_err, 0);
        check_log("stuck", 1, 16, 2);
`ifdef MEM_TESTER_ERR_CAPTURE_EN
        chk("cap_valid", fail_valid, 1);
        chk("cap_addr", fail_addr, 0);
        chk("cap_exp", fail_exp, 0);
        chk("cap_got", fail_got, 16'h0008);
`endif

        // Walking one wraps after DATA_W addresses.
        run(1'b1, 3, 19, 0, 1, 1);
        chk("walk_pass", passcount, 1);
        chk("walk_fail", failcount, 0);
        check_log("walk", 3, 20, 1);
        if (log_q.size() >= 20) begin
            chk("walk_a16", log_q[16].d, 16'h0001);
            chk("walk_a19", log_q[19].d, 16'h0008);
        end else chk("walk_len", log_q.size(), 40);

        // Random mode/range/latency, first one a single-word pass.
        for (int r = 0; r < 3; r++) begin
            int m, al, lat;
            m = int'($urandom_range(3, 0));
            al = (r == 0) ? 0 : int'($urandom_range(9, 1));
            lat = int'($urandom_range(3, 0));
            run(1'b1, m, al, 0, lat, 2);
            chk("rnd_pass", passcount, 2);
            chk("rnd_fail", failcount, 0);
            chk("rnd_hs", hs_err, 0);
            check_log("rnd", m, al + 1, 2);
        end

        // Memory never acks: timeout after TO cycles, stays idle.
        do_reset();
        mode = 2'd0;
        addr_last = AW'(3);
        mem_kind = 2;
        mem_init_done = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 200 && !timeout; i++) tick();
        chk("to_flag", timeout, 1);
        tick();
        chk("to_reqlen", last_run, TO);
        chk("to_req", bus.mem_req, 0);
        chk("to_busy", busy, 0);
        chk("to_pass", passcount, 0);
        tick(10);
        chk("to_idle_req", bus.mem_req, 0);
        chk("to_idle_busy", busy, 0);
        chk("to_sticky", timeout, 1);

        // Reset with a read outstanding, then a stray late ack, then a fresh pass from SEED.
        do_reset();
        mode = 2'd0;
        addr_last = AW'(7);
        mem_kind = 0;
        lat_max = 3;
        enable = 1'b1;
        for (int i = 0; i < 500 && !(bus.mem_req && !bus.mem_we && !bus.mem_ack); i++) tick();
        chk("mid_rd_seen", bus.mem_req && !bus.mem_we, 1);
        rst = 1'b1;
        enable = 1'b0;
        tick();
        chk("mid_req", bus.mem_req, 0);
        chk("mid_pass", passcount, 0);
        chk("mid_fail", failcount, 0);
        chk("mid_busy", busy, 0);
        rst = 1'b0;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick(3);
        chk("stray_req", bus.mem_req, 0);
        chk("stray_busy", busy, 0);
        chk("stray_fail", failcount, 0);
        run(1'b0, 0, 7, 0, 2, 1);
        chk("fresh_pass", passcount, 1);
        chk("fresh_fail", failcount, 0);
        chk("fresh_hs", hs_err, 0);
        check_log("fresh", 0, 8, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
